// File: rtl/counter_run_pause_sched_if.sv
// Control/status bundle between the top-level sequencer control and the
// run/pause counter scheduler.
interface counter_run_pause_sched_if;
    logic       start;
    logic       stop;
    logic       cfg_load;
    logic [3:0] cfg_run;
    logic [3:0] cfg_pause;
    logic [3:0] cfg_grp;
    logic       cfg_ack;
    logic       cfg_err;
    logic       oe;
    logic       parity;
    logic [3:0] q;
    logic       busy;

    modport master (
        output start, stop, cfg_load, cfg_run, cfg_pause, cfg_grp,
        input  cfg_ack, cfg_err, oe, parity, q, busy
    );

    modport slave (
        input  start, stop, cfg_load, cfg_run, cfg_pause, cfg_grp,
        output cfg_ack, cfg_err, oe, parity, q, busy
    );
endinterface

// File: rtl/counter_run_pause_sched.sv
// Run/pause scheduler for a 4-bit counter: alternates enabled RUN bursts with
// held PAUSE gaps while stepping through interleaved even/odd count groups.
module counter_run_pause_sched #(
    parameter logic [3:0] RUN_DEF   = 4'd3,
    parameter logic [3:0] PAUSE_DEF = 4'd2,
    parameter logic [3:0] GRP_DEF   = 4'd3
) (
    input  logic                           clk,
    input  logic                           reset,
    counter_run_pause_sched_if.slave       bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;

    logic [3:0] q_r;
    logic       parity_r;
    logic [3:0] grp_cnt_r;
    logic [3:0] run_cnt_r;
    logic [3:0] pause_cnt_r;
    logic [3:0] run_len_r;
    logic [3:0] pause_len_r;
    logic [3:0] grp_len_r;
    logic       cfg_ack_r;
    logic       cfg_err_r;

    logic       oe_s;
    logic       busy_s;
    logic       run_done_s;
    logic       pause_done_s;
    logic       grp_done_s;
    logic       cfg_take_s;

    // Zero-length runs and groups would never terminate, so they collapse to one.
    function automatic logic [3:0] clamp_min1(input logic [3:0] v);
        return (v == 4'd0) ? 4'd1 : v;
    endfunction

    assign run_done_s   = (run_cnt_r == run_len_r);
    assign pause_done_s = (pause_cnt_r == pause_len_r);
    assign grp_done_s   = (grp_cnt_r == grp_len_r);
    assign cfg_take_s   = (state_r == ST_IDLE) && !bus.stop && bus.cfg_load;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state selection; stop always wins, cfg_load in IDLE masks start.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.stop) begin
                    state_nxt_s = ST_IDLE;
                end else if (bus.cfg_load) begin
                    state_nxt_s = ST_IDLE;
                end else if (bus.start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_nxt_s = ST_IDLE;
                end else if (run_done_s && (pause_len_r == 4'd0)) begin
                    state_nxt_s = ST_RUN;
                end else if (run_done_s) begin
                    state_nxt_s = ST_PAUSE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (bus.stop) begin
                    state_nxt_s = ST_IDLE;
                end else if (pause_done_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Moore output decode from the registered state.
    always_comb begin
        oe_s   = 1'b0;
        busy_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                oe_s   = 1'b1;
                busy_s = 1'b1;
            end
            ST_PAUSE: begin
                oe_s   = 1'b0;
                busy_s = 1'b1;
            end
            default: begin
                oe_s   = 1'b0;
                busy_s = 1'b0;
            end
        endcase
    end

    // Counter datapath, phase counters, configuration and handshake pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_r         <= 4'd0;
            parity_r    <= 1'b0;
            grp_cnt_r   <= 4'd1;
            run_cnt_r   <= 4'd1;
            pause_cnt_r <= 4'd1;
            run_len_r   <= clamp_min1(RUN_DEF);
            pause_len_r <= PAUSE_DEF;
            grp_len_r   <= clamp_min1(GRP_DEF);
            cfg_ack_r   <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            cfg_ack_r <= cfg_take_s;
            cfg_err_r <= bus.cfg_load && (state_r != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (cfg_take_s) begin
                        run_len_r   <= clamp_min1(bus.cfg_run);
                        pause_len_r <= bus.cfg_pause;
                        grp_len_r   <= clamp_min1(bus.cfg_grp);
                        q_r         <= 4'd0;
                        parity_r    <= 1'b0;
                        grp_cnt_r   <= 4'd1;
                    end else if (!bus.stop && bus.start) begin
                        run_cnt_r <= 4'd1;
                    end
                end
                ST_RUN: begin
                    // The group step happens even on the cycle stop is seen.
                    if (grp_done_s) begin
                        q_r       <= q_r + 4'd1;
                        parity_r  <= ~parity_r;
                        grp_cnt_r <= 4'd1;
                    end else begin
                        q_r       <= q_r + 4'd2;
                        grp_cnt_r <= grp_cnt_r + 4'd1;
                    end
                    if (!bus.stop) begin
                        if (run_done_s) begin
                            run_cnt_r   <= 4'd1;
                            pause_cnt_r <= 4'd1;
                        end else begin
                            run_cnt_r <= run_cnt_r + 4'd1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!bus.stop) begin
                        if (pause_done_s) begin
                            run_cnt_r <= 4'd1;
                        end else begin
                            pause_cnt_r <= pause_cnt_r + 4'd1;
                        end
                    end
                end
                default: begin
                    q_r <= q_r;
                end
            endcase
        end
    end

    assign bus.q       = q_r;
    assign bus.parity  = parity_r;
    assign bus.cfg_ack = cfg_ack_r;
    assign bus.cfg_err = cfg_err_r;
    assign bus.oe      = oe_s;
    assign bus.busy    = busy_s;

endmodule

// File: tb/tb_counter_run_pause_sched.sv
// Scoreboard bench for counter_run_pause_sched: each scenario queues the
// expected output word per cycle and checks it against the DUT one cycle later.
module tb_counter_run_pause_sched;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // {oe, busy, parity, q[3:0], cfg_ack, cfg_err}
    logic [8:0] exp_q[$];

    counter_run_pause_sched_if bus ();

    counter_run_pause_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] ev(input logic oe_e, input logic busy_e,
                                      input logic par_e, input logic [3:0] q_e,
                                      input logic ack_e, input logic err_e);
        return {oe_e, busy_e, par_e, q_e, ack_e, err_e};
    endfunction

    function automatic logic [8:0] obs();
        return {bus.oe, bus.busy, bus.parity, bus.q, bus.cfg_ack, bus.cfg_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic ld, input logic [3:0] r, input logic [3:0] p,
                           input logic [3:0] g);
        bus.cfg_load  = ld;
        bus.cfg_run   = r;
        bus.cfg_pause = p;
        bus.cfg_grp   = g;
    endtask

    task automatic do_reset();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        set_cfg(1'b0, 4'd0, 4'd0, 4'd0);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [8:0] exp_v;
        logic [8:0] got;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        set_cfg(1'b0, 4'd0, 4'd0, 4'd0);
        reset = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) tick();
            if (i == 2) begin
                reset = 1'b1;
                tick();
            end
            exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
            exp_v = exp_q.pop_front();
            got   = obs();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL reset[%0d]: got oe,busy,par,q,ack,err=%b want %b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_default_pattern();
        logic [8:0] exp_v;
        logic [8:0] got;
        logic [3:0] qs [19];
        logic       os [19];
        logic       ps [19];
        qs = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd5, 4'd5, 4'd7, 4'd9, 4'd10, 4'd10,
               4'd10, 4'd12, 4'd14, 4'd15, 4'd15, 4'd15, 4'd1, 4'd3, 4'd4};
        os = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
               1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        ps = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bus.start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 19) begin
                bus.start = 1'b0;
                bus.stop  = 1'b1;
                exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0));
            end else begin
                exp_q.push_back(ev(os[i], 1'b1, ps[i], qs[i], 1'b0, 1'b0));
            end
            tick();
            exp_v = exp_q.pop_front();
            got   = obs();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL default_pattern[%0d]: got oe,busy,par,q,ack,err=%b want %b", i, got, exp_v);
            end
        end
        bus.stop = 1'b0;
    endtask

    task automatic test_cfg_load();
        logic [8:0] exp_v;
        logic [8:0] got;
        logic [3:0] qs [8];
        logic       ps [8];
        qs = '{4'd0, 4'd2, 4'd3, 4'd5, 4'd6, 4'd8, 4'd9, 4'd11};
        ps = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                // start asserted alongside cfg_load must be ignored
                set_cfg(1'b1, 4'd4, 4'd0, 4'd2);
                bus.start = 1'b1;
                exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0));
            end else if (i == 9) begin
                bus.start = 1'b0;
                bus.stop  = 1'b1;
                exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 4'd12, 1'b0, 1'b0));
            end else begin
                bus.cfg_load = 1'b0;
                exp_q.push_back(ev(1'b1, 1'b1, ps[i-1], qs[i-1], 1'b0, 1'b0));
            end
            tick();
            exp_v = exp_q.pop_front();
            got   = obs();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL cfg_load[%0d]: got oe,busy,par,q,ack,err=%b want %b", i, got, exp_v);
            end
        end
        bus.stop = 1'b0;
    endtask

    task automatic test_stop_resume();
        logic [8:0] exp_v;
        logic [8:0] got;
        logic [8:0] tbl [7];
        tbl = '{ev(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0),
                ev(1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0),
                ev(1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0),
                ev(1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0),
                ev(1'b1, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0),
                ev(1'b1, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0),
                ev(1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0)};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            bus.start = (i < 2) || (i == 4) || (i == 5);
            bus.stop  = (i == 2) || (i == 6);
            exp_q.push_back(tbl[i]);
            tick();
            exp_v = exp_q.pop_front();
            got   = obs();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL stop_resume[%0d]: got oe,busy,par,q,ack,err=%b want %b", i, got, exp_v);
            end
        end
        bus.stop = 1'b0;
    endtask

    task automatic test_cfg_err();
        logic [8:0] exp_v;
        logic [8:0] got;
        logic [8:0] tbl [11];
        tbl = '{ev(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0),
                ev(1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0),
                ev(1'b1, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0),
                ev(1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0),
                ev(1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b1),
                ev(1'b1, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0),
                ev(1'b1, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0),
                ev(1'b1, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0),
                ev(1'b0, 1'b1, 1'b0, 4'd10, 1'b0, 1'b0),
                ev(1'b0, 1'b0, 1'b0, 4'd10, 1'b0, 1'b0),
                ev(1'b0, 1'b0, 1'b0, 4'd10, 1'b0, 1'b0)};
        do_reset();
        set_cfg(1'b0, 4'd1, 4'd0, 4'd1);
        for (int i = 0; i < 11; i++) begin
            bus.start    = (i < 9);
            bus.stop     = (i >= 9);
            // i==10: stop in IDLE outranks cfg_load, so no ack either
            bus.cfg_load = (i == 4) || (i == 10);
            exp_q.push_back(tbl[i]);
            tick();
            exp_v = exp_q.pop_front();
            got   = obs();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL cfg_err[%0d]: got oe,busy,par,q,ack,err=%b want %b", i, got, exp_v);
            end
        end
        bus.stop     = 1'b0;
        bus.cfg_load = 1'b0;
    endtask

    task automatic test_zero_clamp();
        logic [8:0] exp_v;
        logic [8:0] got;
        logic [3:0] qv;
        for (int i = 0; i < 7; i++) begin
            if (i == 0) begin
                set_cfg(1'b1, 4'd0, 4'd0, 4'd0);
                exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0));
            end else begin
                bus.cfg_load = 1'b0;
                bus.start    = 1'b1;
                qv = 4'(i - 1);
                exp_q.push_back(ev(1'b1, 1'b1, qv[0], qv, 1'b0, 1'b0));
            end
            tick();
            exp_v = exp_q.pop_front();
            got   = obs();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL zero_clamp[%0d]: got oe,busy,par,q,ack,err=%b want %b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [8:0] exp_v;
        logic [8:0] got;
        logic [8:0] tbl [7];
        tbl = '{ev(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0),
                ev(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0),
                ev(1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0),
                ev(1'b1, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0),
                ev(1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0),
                ev(1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0),
                ev(1'b1, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0)};
        // still running the clamped config from the previous scenario
        #2;
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(tbl[i]);
            if (i == 0) begin
                #1;
            end else begin
                if (i == 1) begin
                    #1;
                    reset = 1'b1;
                end
                tick();
            end
            exp_v = exp_q.pop_front();
            got   = obs();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL async_reset[%0d]: got oe,busy,par,q,ack,err=%b want %b", i, got, exp_v);
            end
        end
        bus.start = 1'b0;
        bus.stop  = 1'b1;
        tick();
        bus.stop  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_default_pattern();
        test_cfg_load();
        test_stop_resume();
        test_cfg_err();
        test_zero_clamp();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
